// File: rtl/dbg_apb_bridge.sv
// Byte-stream to APB master bridge for the debugger register file.
// Command bytes arrive on a valid/ready stream: bit7 selects write (1) or
// read (0), bits4:0 give the register address, and bits6:5 are reserved.
// A write command is followed by one data byte. A read returns one byte on
// the TX stream. ACCESS is bounded by a PREADY timeout so the transport
// cannot hang on a stalled slave. Every output comes straight from a flop.
module dbg_apb_bridge #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  TIMEOUT_DATA   = 8'hFF
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       RX_READY,
  output logic [7:0] TX_DATA,
  output logic       TX_VALID,
  input  logic       TX_READY,
  output logic       PSEL,
  output logic [4:0] PADDR,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  output logic       BUSY,
  output logic       TIMEOUT_ERR
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The count before the final ACCESS edge; reaching it with PREADY low aborts.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WDATA  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  logic [2:0]       state_r,    state_nxt_s;
  logic [CNT_W-1:0] cnt_r,      cnt_nxt_s;
  logic             rx_ready_r, rx_ready_nxt_s;
  logic [7:0]       tx_data_r,  tx_data_nxt_s;
  logic             tx_valid_r, tx_valid_nxt_s;
  logic             psel_r,     psel_nxt_s;
  logic [4:0]       paddr_r,    paddr_nxt_s;
  logic             penable_r,  penable_nxt_s;
  logic             pwrite_r,   pwrite_nxt_s;
  logic [7:0]       pwdata_r,   pwdata_nxt_s;
  logic             busy_r,     busy_nxt_s;
  logic             tmo_err_r,  tmo_err_nxt_s;
  logic             rx_fire_s;
  logic             unused_rsvd_s;

  assign rx_fire_s     = RX_VALID & rx_ready_r;
  // Reserved command bits carry no meaning.
  assign unused_rsvd_s = ^RX_DATA[6:5];

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    rx_ready_nxt_s = rx_ready_r;
    tx_data_nxt_s  = tx_data_r;
    tx_valid_nxt_s = tx_valid_r;
    psel_nxt_s     = psel_r;
    paddr_nxt_s    = paddr_r;
    penable_nxt_s  = penable_r;
    pwrite_nxt_s   = pwrite_r;
    pwdata_nxt_s   = pwdata_r;
    tmo_err_nxt_s  = tmo_err_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_fire_s) begin
          paddr_nxt_s  = RX_DATA[4:0];
          pwrite_nxt_s = RX_DATA[7];
          if (RX_DATA[7]) begin
            state_nxt_s = ST_WDATA;
          end else begin
            state_nxt_s    = ST_SETUP;
            psel_nxt_s     = 1'b1;
            rx_ready_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (rx_fire_s) begin
          pwdata_nxt_s   = RX_DATA;
          state_nxt_s    = ST_SETUP;
          psel_nxt_s     = 1'b1;
          rx_ready_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_WDATA;
        end
      end
      ST_SETUP: begin
        state_nxt_s   = ST_ACCESS;
        penable_nxt_s = 1'b1;
      end
      ST_ACCESS: begin
        // PREADY wins over a timeout reached on the same edge.
        if (PREADY || (cnt_r == CNT_LAST)) begin
          psel_nxt_s    = 1'b0;
          penable_nxt_s = 1'b0;
          cnt_nxt_s     = CNT_ZERO;
          if (!PREADY) begin
            tmo_err_nxt_s = 1'b1;
          end else begin
            tmo_err_nxt_s = tmo_err_r;
          end
          if (pwrite_r) begin
            state_nxt_s    = ST_IDLE;
            rx_ready_nxt_s = 1'b1;
          end else begin
            state_nxt_s    = ST_RESP;
            tx_valid_nxt_s = 1'b1;
            tx_data_nxt_s  = PREADY ? PRDATA : TIMEOUT_DATA;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RESP: begin
        if (TX_READY) begin
          tx_valid_nxt_s = 1'b0;
          rx_ready_nxt_s = 1'b1;
          state_nxt_s    = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        cnt_nxt_s      = CNT_ZERO;
        rx_ready_nxt_s = 1'b1;
        tx_valid_nxt_s = 1'b0;
        psel_nxt_s     = 1'b0;
        penable_nxt_s  = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers; reset drops the APB strobes immediately.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      rx_ready_r <= 1'b1;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      psel_r     <= 1'b0;
      paddr_r    <= 5'h00;
      penable_r  <= 1'b0;
      pwrite_r   <= 1'b0;
      pwdata_r   <= 8'h00;
      busy_r     <= 1'b0;
      tmo_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      rx_ready_r <= rx_ready_nxt_s;
      tx_data_r  <= tx_data_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
      psel_r     <= psel_nxt_s;
      paddr_r    <= paddr_nxt_s;
      penable_r  <= penable_nxt_s;
      pwrite_r   <= pwrite_nxt_s;
      pwdata_r   <= pwdata_nxt_s;
      busy_r     <= busy_nxt_s;
      tmo_err_r  <= tmo_err_nxt_s;
    end
  end

  assign RX_READY    = rx_ready_r;
  assign TX_DATA     = tx_data_r;
  assign TX_VALID    = tx_valid_r;
  assign PSEL        = psel_r;
  assign PADDR       = paddr_r;
  assign PENABLE     = penable_r;
  assign PWRITE      = pwrite_r;
  assign PWDATA      = pwdata_r;
  assign BUSY        = busy_r;
  assign TIMEOUT_ERR = tmo_err_r;

endmodule

// File: tb/tb_dbg_apb_bridge.sv
// Directed bench for dbg_apb_bridge: reads, writes, wait states, timeout,
// TX backpressure, streamed writes and reset during ACCESS.
module tb_dbg_apb_bridge;

  logic       PCLK;
  logic       PRESET;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       PSEL;
  logic [4:0] PADDR;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       BUSY;
  logic       TIMEOUT_ERR;

  int checks = 0;
  int errors = 0;

  dbg_apb_bridge #(.TIMEOUT_CYCLES(16), .TIMEOUT_DATA(8'hFF)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1ns past the edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    PRESET   = 1'b1;
    RX_DATA  = 8'h00;
    RX_VALID = 1'b0;
    TX_READY = 1'b0;
    PRDATA   = 8'h00;
    PREADY   = 1'b0;
    tick();
    tick();
    chk("rst_rx_ready", RX_READY, 1);
    chk("rst_tx_valid", TX_VALID, 0);
    chk("rst_tx_data", TX_DATA, 8'h00);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 5'h00);
    chk("rst_pwdata", PWDATA, 8'h00);
    chk("rst_busy", BUSY, 0);
    chk("rst_tmo", TIMEOUT_ERR, 0);
    PRESET = 1'b0;
    tick();

    // Zero-wait read of address 0
    PREADY = 1'b1; PRDATA = 8'h09;
    RX_DATA = 8'h00; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    chk("rd_setup_psel", PSEL, 1);
    chk("rd_setup_penable", PENABLE, 0);
    chk("rd_setup_rx_ready", RX_READY, 0);
    chk("rd_setup_paddr", PADDR, 5'h00);
    chk("rd_setup_pwrite", PWRITE, 0);
    chk("rd_setup_busy", BUSY, 1);
    tick();
    chk("rd_access_psel", PSEL, 1);
    chk("rd_access_penable", PENABLE, 1);
    chk("rd_access_tx_valid", TX_VALID, 0);
    tick();
    chk("rd_resp_tx_valid", TX_VALID, 1);
    chk("rd_resp_tx_data", TX_DATA, 8'h09);
    chk("rd_resp_psel", PSEL, 0);
    chk("rd_resp_penable", PENABLE, 0);
    tick();
    chk("rd_hold_tx_valid", TX_VALID, 1);
    chk("rd_hold_tx_data", TX_DATA, 8'h09);
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    chk("rd_done_tx_valid", TX_VALID, 0);
    chk("rd_done_rx_ready", RX_READY, 1);
    chk("rd_done_busy", BUSY, 0);

    // Write 0x01 to address 0
    RX_DATA = 8'h80; RX_VALID = 1'b1;
    tick();
    chk("wr_wdata_rx_ready", RX_READY, 1);
    chk("wr_wdata_psel", PSEL, 0);
    chk("wr_wdata_pwrite", PWRITE, 1);
    chk("wr_wdata_busy", BUSY, 1);
    RX_DATA = 8'h01;
    tick();
    RX_VALID = 1'b0;
    chk("wr_setup_psel", PSEL, 1);
    chk("wr_setup_penable", PENABLE, 0);
    chk("wr_setup_pwdata", PWDATA, 8'h01);
    chk("wr_setup_paddr", PADDR, 5'h00);
    tick();
    chk("wr_access_penable", PENABLE, 1);
    chk("wr_access_pwrite", PWRITE, 1);
    tick();
    chk("wr_done_penable", PENABLE, 0);
    chk("wr_done_psel", PSEL, 0);
    chk("wr_done_tx_valid", TX_VALID, 0);
    chk("wr_done_busy", BUSY, 0);
    tick();
    chk("wr_idle_tx_valid", TX_VALID, 0);

    // Read 0x1F with three wait states
    PREADY = 1'b0; PRDATA = 8'h33;
    RX_DATA = 8'h1F; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    chk("ws_setup_paddr", PADDR, 5'h1F);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("ws_access_penable", PENABLE, 1);
      chk("ws_access_paddr", PADDR, 5'h1F);
      chk("ws_access_tx_valid", TX_VALID, 0);
    end
    PREADY = 1'b1; PRDATA = 8'hA5;
    tick();
    PREADY = 1'b0; PRDATA = 8'h00;
    chk("ws_resp_penable", PENABLE, 0);
    chk("ws_resp_tx_valid", TX_VALID, 1);
    chk("ws_resp_tx_data", TX_DATA, 8'hA5);
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    chk("ws_done_busy", BUSY, 0);

    // Read timeout: PREADY never rises
    RX_DATA = 8'h03; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("to_access_penable", PENABLE, 1);
      chk("to_access_tmo", TIMEOUT_ERR, 0);
    end
    tick();
    chk("to_resp_penable", PENABLE, 0);
    chk("to_resp_psel", PSEL, 0);
    chk("to_resp_tx_valid", TX_VALID, 1);
    chk("to_resp_tx_data", TX_DATA, 8'hFF);
    chk("to_resp_tmo", TIMEOUT_ERR, 1);

    // Backpressure on the timed-out response
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_tx_valid", TX_VALID, 1);
      chk("bp_tx_data", TX_DATA, 8'hFF);
      chk("bp_rx_ready", RX_READY, 0);
    end
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    chk("bp_done_tx_valid", TX_VALID, 0);
    chk("bp_done_rx_ready", RX_READY, 1);

    // Two streamed writes with RX_VALID held high
    PREADY = 1'b1;
    RX_DATA = 8'h85; RX_VALID = 1'b1;
    tick();
    chk("b2b_w1_paddr", PADDR, 5'h05);
    chk("b2b_w1_wdata_penable", PENABLE, 0);
    RX_DATA = 8'h3C;
    tick();
    chk("b2b_w1_setup_psel", PSEL, 1);
    chk("b2b_w1_pwdata", PWDATA, 8'h3C);
    RX_DATA = 8'h9E;
    tick();
    chk("b2b_w1_access_penable", PENABLE, 1);
    tick();
    chk("b2b_gap_idle_penable", PENABLE, 0);
    chk("b2b_gap_idle_busy", BUSY, 0);
    tick();
    chk("b2b_gap_wdata_penable", PENABLE, 0);
    chk("b2b_w2_paddr", PADDR, 5'h1E);
    RX_DATA = 8'h5A;
    tick();
    RX_VALID = 1'b0;
    chk("b2b_gap_setup_penable", PENABLE, 0);
    chk("b2b_w2_pwdata", PWDATA, 8'h5A);
    tick();
    chk("b2b_w2_access_penable", PENABLE, 1);
    chk("b2b_w2_access_paddr", PADDR, 5'h1E);
    tick();
    chk("b2b_w2_done_penable", PENABLE, 0);
    chk("b2b_tmo_sticky", TIMEOUT_ERR, 1);

    // Reset asserted during ACCESS
    PREADY = 1'b0;
    RX_DATA = 8'h02; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    tick();
    chk("rst_mid_psel_before", PSEL, 1);
    chk("rst_mid_penable_before", PENABLE, 1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("rst_mid_psel", PSEL, 0);
    chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_tmo", TIMEOUT_ERR, 0);
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    chk("rst_rel_rx_ready", RX_READY, 1);
    chk("rst_rel_tx_valid", TX_VALID, 0);
    chk("rst_rel_busy", BUSY, 0);
    PREADY = 1'b1; PRDATA = 8'h77;
    RX_DATA = 8'h04; RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    chk("post_rst_setup_paddr", PADDR, 5'h04);
    chk("post_rst_setup_psel", PSEL, 1);
    tick();
    chk("post_rst_access_penable", PENABLE, 1);
    tick();
    chk("post_rst_tx_valid", TX_VALID, 1);
    chk("post_rst_tx_data", TX_DATA, 8'h77);
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    chk("post_rst_done_tx_valid", TX_VALID, 0);
    chk("post_rst_done_busy", BUSY, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
